// File: rtl/div_pkg.sv
//==============================================================================
// div_pkg -- shared encodings and constants for the div sequential divider
// Rev 1.0
//==============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam int          DoubleRegisterBus = 64;
  localparam logic        ResetEnable       = 1'b0;
  localparam logic [5:0]  C_DIV_STEPS       = 6'd32;

  // Two's-complement magnitude of a word when neg is set.
  function automatic logic [31:0] abs_word(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div.sv
//==============================================================================
// div -- 32-cycle restoring radix-2 divider, result = {remainder, quotient}.
// Optional macro DIV_SIGNED_EN enables signed (DIV) operation. Rev 1.0
//==============================================================================
`default_nettype none

module div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               signed_div_input,
  input  logic [WIDTH-1:0]   opdata1_input,
  input  logic [WIDTH-1:0]   opdata2_input,
  input  logic               start_input,
  input  logic               annul_input,
  output logic [2*WIDTH-1:0] result_output,
  output logic               ready_output
);

  div_state_e         r_state, w_state_nxt;
  logic [5:0]         r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_quo, w_quo_nxt;
  logic [WIDTH-1:0]   r_rem, w_rem_nxt;
  logic [WIDTH-1:0]   r_divisor, w_divisor_nxt;
  logic [2*WIDTH-1:0] w_result_nxt;
  logic               w_ready_nxt;

  logic               w_accept;
  logic [WIDTH-1:0]   w_mag1, w_mag2;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
  logic [WIDTH:0]     w_shift, w_trial;

  assign w_accept = (start_input == DivStart) && !annul_input;

`ifdef DIV_SIGNED_EN
  logic w_neg1, w_neg2;
  logic r_neg_quo, r_neg_rem;

  assign w_neg1    = signed_div_input & opdata1_input[WIDTH-1];
  assign w_neg2    = signed_div_input & opdata2_input[WIDTH-1];
  assign w_mag1    = abs_word(w_neg1, opdata1_input);
  assign w_mag2    = abs_word(w_neg2, opdata2_input);
  assign w_quo_fix = abs_word(r_neg_quo, r_quo);
  assign w_rem_fix = abs_word(r_neg_rem, r_rem);

  // Signs captured alongside the magnitudes; the fix-up re-applies them.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == ResetEnable) begin
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (r_state == DivFree && w_accept) begin
      r_neg_quo <= w_neg1 ^ w_neg2;
      r_neg_rem <= w_neg1;
    end
  end
`else
  logic w_unused_signed;
  assign w_unused_signed = signed_div_input;
  assign w_mag1    = opdata1_input;
  assign w_mag2    = opdata2_input;
  assign w_quo_fix = r_quo;
  assign w_rem_fix = r_rem;
`endif

  // r_quo starts as the dividend; its MSB feeds the remainder as quotient bits enter at the LSB.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_divisor};

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_quo_nxt     = r_quo;
    w_rem_nxt     = r_rem;
    w_divisor_nxt = r_divisor;
    w_result_nxt  = result_output;
    w_ready_nxt   = ready_output;
    case (r_state)
      DivFree: begin
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = {ZeroWord, ZeroWord};
        if (w_accept) begin
          if (opdata2_input == ZeroWord) begin
            w_state_nxt = DivByZero;
          end else begin
            w_state_nxt   = DivOn;
            w_cnt_nxt     = 6'd0;
            w_quo_nxt     = w_mag1;
            w_rem_nxt     = ZeroWord;
            w_divisor_nxt = w_mag2;
          end
        end
      end
      DivByZero: begin
        w_state_nxt  = DivEnd;
        w_result_nxt = {ZeroWord, ZeroWord};
        w_ready_nxt  = DivResultReady;
      end
      DivOn: begin
        if (annul_input) begin
          w_state_nxt = DivFree;
        end else if (r_cnt != C_DIV_STEPS) begin
          w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
          w_cnt_nxt = r_cnt + 6'd1;
        end else begin
          w_state_nxt  = DivEnd;
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_input == DivStop) begin
          w_state_nxt  = DivFree;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = {ZeroWord, ZeroWord};
        end
      end
      default: w_state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (reset == ResetEnable) begin
      r_state       <= DivFree;
      r_cnt         <= 6'd0;
      r_quo         <= ZeroWord;
      r_rem         <= ZeroWord;
      r_divisor     <= ZeroWord;
      result_output <= {ZeroWord, ZeroWord};
      ready_output  <= DivResultNotReady;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_quo         <= w_quo_nxt;
      r_rem         <= w_rem_nxt;
      r_divisor     <= w_divisor_nxt;
      result_output <= w_result_nxt;
      ready_output  <= w_ready_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div.sv
//==============================================================================
// tb_div -- randomized self-checking bench for div against an arithmetic model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_div;

  logic        clock;
  logic        reset;
  logic        signed_div;
  logic [31:0] opa, opb;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_checks = 0;
  int n_pass   = 0;

  div #(.WIDTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .signed_div_input (signed_div),
    .opdata1_input    (opa),
    .opdata2_input    (opb),
    .start_input      (start),
    .annul_input      (annul),
    .result_output    (result),
    .ready_output     (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected result from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      q32 = q[31:0];
      r32 = r[31:0];
      return {r32, q32};
    end
`endif
    q32 = a / b;
    r32 = a % b;
    return {r32, q32};
  endfunction

  // Transaction-level model: idle / busy-for-N-edges / done.
  int          m_phase;
  int          m_left;
  logic        m_zero;
  logic [63:0] m_res;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase <= 0;
      m_left  <= 0;
      m_zero  <= 1'b0;
      m_res   <= 64'd0;
    end else begin
      case (m_phase)
        0: if (start && !annul) begin
          m_phase <= 1;
          m_zero  <= (opb == 32'd0);
          m_left  <= (opb == 32'd0) ? 1 : 33;
          m_res   <= ref_div(opa, opb, signed_div);
        end
        1: begin
          if (!m_zero && annul) m_phase <= 0;
          else if (m_left == 1) m_phase <= 2;
          else m_left <= m_left - 1;
        end
        default: if (!start) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clock) begin
    logic        e_ready;
    logic [63:0] e_res;
    e_ready = (m_phase == 2);
    e_res   = e_ready ? m_res : 64'd0;
    n_checks++;
    if (ready !== e_ready || result !== e_res)
      $display("FAIL cycle_cmp t=%0t ready=%b result=%h expected ready=%b result=%h",
               $time, ready, result, e_ready, e_res);
    else
      n_pass++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else n_pass++;
  endtask

  // Runs one operation; annul_at>0 annuls after that edge, drop_at>0 drops start early.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int annul_at, input int drop_at, input bit scramble,
                        output logic [63:0] res);
    int cyc;
    bit got;
    @(posedge clock); #2;
    opa = a; opb = b; signed_div = s; start = 1'b1; annul = 1'b0;
    cyc = 0; got = 0; res = 64'd0;
    if (annul_at > 0) begin
      repeat (annul_at) begin
        @(posedge clock); #2;
        if (scramble) begin opa = $urandom; opb = $urandom; end
      end
      annul = 1'b1; start = 1'b0;
      @(posedge clock); #2;
      annul = 1'b0;
      repeat (40) @(posedge clock);
      chk("annul_no_ready", {63'd0, ready}, 64'd0);
      return;
    end
    while (!got && cyc < 60) begin
      @(posedge clock); cyc++; #1;
      if (ready) begin
        got = 1;
        res = result;
      end else begin
        if (cyc == drop_at) start = 1'b0;
        if (scramble && cyc > 1) begin opa = $urandom; opb = $urandom; signed_div = $urandom; end
      end
    end
    if (!got) $display("FAIL ready_timeout cycles=%0d expected ready within 60", cyc);
    n_checks++;
    if (got) n_pass++;
    chk("latency", 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd34);
    start = 1'b0;
  endtask

  logic [63:0] r;

  initial begin
    reset = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clock);
    #1 chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    #1 reset = 1'b1;

    chk("model_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    do_div(32'd100, 32'd7, 1'b0, 0, 0, 0, r);
    chk("udiv_100_7", r, 64'h00000002_0000000E);

    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, 0, 0, r);
`ifdef DIV_SIGNED_EN
    chk("sdiv_m7_2", r, 64'hFFFFFFFF_FFFFFFFD);
`else
    chk("udiv_fff9_2", r, 64'h00000001_7FFFFFFC);
`endif

    do_div(32'h1234, 32'd0, 1'b0, 0, 0, 0, r);
    chk("div_by_zero", r, 64'd0);

    do_div(32'd1000, 32'd3, 1'b0, 11, 0, 0, r);
    do_div(32'd9, 32'd3, 1'b0, 0, 0, 0, r);
    chk("after_annul_9_3", r, 64'h00000000_00000003);

    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, 0, r);
`ifdef DIV_SIGNED_EN
    chk("sdiv_min_m1", r, 64'h00000000_80000000);
`else
    chk("udiv_min_max", r, 64'h80000000_00000000);
`endif

    do_div(32'd77, 32'd5, 1'b0, 0, 6, 1, r);
    chk("start_drop_77_5", r, 64'h00000002_0000000F);

    // Reset 20 cycles into the iteration phase.
    @(posedge clock); #2;
    opa = 32'd123456; opb = 32'd789; start = 1'b1;
    repeat (21) @(posedge clock);
    #2 reset = 1'b0;
    #1 chk("async_reset_on_ready", {63'd0, ready}, 64'd0);
    chk("async_reset_on_result", result, 64'd0);
    start = 1'b0;
    @(posedge clock); #2 reset = 1'b1;
    do_div(32'd50, 32'd5, 1'b0, 0, 0, 0, r);
    chk("after_reset_50_5", r, 64'h00000000_0000000A);

    // Reset while a result is being presented.
    @(posedge clock); #2;
    opa = 32'd40; opb = 32'd6; start = 1'b1;
    repeat (34) @(posedge clock);
    #2 chk("end_ready_before_reset", {63'd0, ready}, 64'd1);
    reset = 1'b0;
    #1 chk("async_reset_end_ready", {63'd0, ready}, 64'd0);
    chk("async_reset_end_result", result, 64'd0);
    start = 1'b0;
    @(posedge clock); #2 reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      int kind;
      kind = $urandom_range(0, 9);
      a = $urandom;
      b = (kind == 0) ? 32'd0 : (kind < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      if (kind == 9) a = 32'h80000000;
      do_div(a, b, 1'($urandom), (kind == 8 && b != 0) ? int'($urandom_range(1, 33)) : 0,
             (kind == 7) ? 5 : 0, 1, r);
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; only 32 is supported.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port signed_div_input  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-005 SHALL have port opdata1_input  input  32  dividend; sampled with start.
REQ-006 SHALL have port opdata2_input  input  32  divisor; sampled with start.
REQ-007 SHALL have port start_input  input  1  request a division; held high by EX until ready is seen.
REQ-008 SHALL have port annul_input  input  1  abort the operation in progress (pipeline flush).
REQ-009 SHALL have port result_output  output  64  {remainder[63:32], quotient[31:0]}, registered.
REQ-010 SHALL have port ready_output  output  1  result valid, registered.

Function
REQ-011 SHALL implement a four-state FSM: FREE, BY_ZERO, ON, END.
REQ-012 In FREE with start=1 and annul=0, the next edge SHALL go to BY_ZERO if divisor=0, else to ON with iteration count 0 and operands latched.
REQ-013 When latching in signed mode, a negative operand SHALL be replaced by its two's-complement magnitude; original signs SHALL be kept.
REQ-014 In FREE with start=0 or annul=1: ready=0, result=0, state held.
REQ-015 BY_ZERO SHALL go to END on the next edge with quotient=0 and remainder=0.
REQ-016 ON SHALL perform one restoring radix-2 step per cycle, producing quotient bits MSB first; 32 steps total.
REQ-017 Each step: trial = partial_remainder[32:0] - {1'b0,divisor}; if non-negative, keep trial and shift in 1; else shift in 0.
REQ-018 When the count reaches 32, the next edge SHALL apply sign fix-up and go to END.
REQ-019 Sign fix-up (signed only): negate the quotient if the dividend and divisor signs differ; give the remainder the sign of the dividend.
REQ-020 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000 and remainder 0, with no exception.
REQ-021 annul=1 in ON SHALL return the FSM to FREE on the next edge; ready SHALL never assert for that operation.
REQ-022 start deasserting during ON SHALL be ignored; the division SHALL continue.
REQ-023 In END, ready=1 and result SHALL be stable; when start=0 is seen, the next edge SHALL go to FREE with ready=0 and result=0.
REQ-024 Latency, counted from the edge that samples start: ready SHALL go high after edge 34 (nonzero divisor) or after edge 2 (zero divisor).
REQ-025 In FREE, a start arriving in the cycle after END SHALL be accepted normally, with no extra dead cycle.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for a clock edge, force state=FREE, count=0, ready=0 and result=0, including mid-operation.
REQ-027 The first start after reset is released SHALL be accepted on the first rising edge.

Configuration
REQ-028 With DIV_SIGNED_EN defined, signed_div_input SHALL select signed or unsigned operation per REQ-013 and REQ-019.
REQ-029 Without DIV_SIGNED_EN, signed_div_input SHALL be ignored: every operation is unsigned and the sign/fix-up logic is absent.

Structure
REQ-030 The shared defines header SHALL hold:
- state encodings DivFree, DivByZero, DivOn, DivEnd;
- DivResultReady / DivResultNotReady;
- DivStart / DivStop;
- ZeroWord, DoubleRegisterBus, ResetEnable.
REQ-031 SHALL be a single module; no sub-module is required, and the step datapath is inline.

Verification
REQ-032 Unsigned 100 / 7 -> result 0x00000002_0000000E; ready rises 34 cycles after start.
REQ-033 Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-034 Divisor 0 (dividend 0x1234) -> result 0; ready rises 2 cycles after start.
REQ-035 annul pulsed 10 cycles into ON -> FSM returns to FREE, ready stays 0; a following 9 / 3 -> quotient 3, remainder 0.
REQ-036 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-037 reset driven low 20 cycles into ON -> ready=0 and result=0 immediately; 50 / 5 after release -> quotient 10, remainder 0.
